alarm_ctrl: RTL and testbench

ALARM_CTRL -- requirements
Module: alarm_ctrl

---
 rtl/alarm_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_alarm_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: stores a BCD alarm time, compares it against the
// real-time clock on each new second, and handles ring, snooze, stop and timeout.
module alarm_ctrl #(
    parameter int unsigned SNOOZE_MIN = 5,   // snooze interval in minutes (1..9)
    parameter int unsigned RING_SEC   = 60,  // ring timeout in new-second events (1..255)
    parameter int unsigned MAX_SNOOZE = 3    // snoozes allowed per alarm event (1..7)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [21:0] r_clock,
    input  logic        set_valid,
    input  logic [21:0] set_time,
    output logic        set_ready,
    input  logic        arm_en,
    input  logic        snooze,
    input  logic        stop,
    output logic        alarm_on,
    output logic [21:0] alarm_time,
    output logic [2:0]  snooze_cnt,
    output logic        set_err,
    output logic        missed
);

    localparam logic [3:0] SnoozeMinBcd = 4'(SNOOZE_MIN);
    localparam logic [7:0] RingSecW     = 8'(RING_SEC);
    localparam logic [2:0] MaxSnoozeW   = 3'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StRinging,
        StSnoozed
    } state_e;

    state_e      state_q, state_d;
    logic        alarm_on_q, alarm_on_d;
    logic [21:0] alarm_time_q, alarm_time_d;
    logic [21:0] snooze_tgt_q, snooze_tgt_d;
    logic [2:0]  snooze_cnt_q, snooze_cnt_d;
    logic [7:0]  ring_cnt_q, ring_cnt_d;
    logic        set_err_q, set_err_d;
    logic        missed_q, missed_d;
    logic [21:0] prev_clk_q;
    logic        first_q;
    logic        new_sec;

    // Every BCD digit in range, minutes/seconds tens <= 5, hours <= 23.
    function automatic logic bcd_valid(input logic [21:0] t);
        logic hours_ok;
        hours_ok = (t[21:20] <= 2'd1) || ((t[21:20] == 2'd2) && (t[19:16] <= 4'd3));
        return hours_ok && (t[19:16] <= 4'd9) && (t[15:12] <= 4'd5) && (t[11:8] <= 4'd9)
               && (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9);
    endfunction

    // Adds SNOOZE_MIN minutes in BCD; seconds pass through, 23 wraps to 00.
    function automatic logic [21:0] add_snooze(input logic [21:0] t);
        logic [4:0] mu;
        logic [3:0] mt;
        logic [3:0] hu;
        logic [1:0] ht;
        logic       c_min;
        logic       c_hr;
        mu    = {1'b0, t[11:8]} + {1'b0, SnoozeMinBcd};
        c_min = (mu >= 5'd10);
        if (c_min) begin
            mu = mu - 5'd10;
        end
        mt   = t[15:12] + {3'b000, c_min};
        c_hr = (mt == 4'd6);
        if (c_hr) begin
            mt = 4'd0;
        end
        ht = t[21:20];
        hu = t[19:16];
        if (c_hr) begin
            if ((ht == 2'd2) && (hu == 4'd3)) begin
                ht = 2'd0;
                hu = 4'd0;
            end else if (hu == 4'd9) begin
                hu = 4'd0;
                ht = ht + 2'd1;
            end else begin
                hu = hu + 4'd1;
            end
        end
        return {ht, hu, mt, mu[3:0], t[7:0]};
    endfunction

    // A second boundary is any change of r_clock, except the first sample after reset.
    assign new_sec   = !first_q && (r_clock != prev_clk_q);
    assign set_ready = (state_q == StIdle) || (state_q == StArmed);

    // Next-state and registered-output logic; arm_en low overrides the FSM.
    always_comb begin
        state_d      = state_q;
        alarm_on_d   = alarm_on_q;
        alarm_time_d = alarm_time_q;
        snooze_tgt_d = snooze_tgt_q;
        snooze_cnt_d = snooze_cnt_q;
        ring_cnt_d   = ring_cnt_q;
        set_err_d    = 1'b0;
        missed_d     = 1'b0;

        if (set_valid && set_ready) begin
            if (bcd_valid(set_time)) begin
                alarm_time_d = set_time;
                snooze_cnt_d = 3'd0;
            end else begin
                set_err_d = 1'b1;
            end
        end

        if (!arm_en) begin
            state_d      = StIdle;
            alarm_on_d   = 1'b0;
            snooze_cnt_d = 3'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StArmed;
                end
                StArmed: begin
                    if (new_sec && (r_clock == alarm_time_q)) begin
                        state_d    = StRinging;
                        alarm_on_d = 1'b1;
                        ring_cnt_d = 8'd0;
                    end
                end
                StRinging: begin
                    // A snooze with the budget used up behaves exactly like stop.
                    if (stop || (snooze && (snooze_cnt_q >= MaxSnoozeW))) begin
                        state_d      = StArmed;
                        alarm_on_d   = 1'b0;
                        snooze_cnt_d = 3'd0;
                    end else if (snooze) begin
                        state_d      = StSnoozed;
                        alarm_on_d   = 1'b0;
                        snooze_cnt_d = snooze_cnt_q + 3'd1;
                        snooze_tgt_d = add_snooze(r_clock);
                    end else if (new_sec) begin
                        if (ring_cnt_q == (RingSecW - 8'd1)) begin
                            state_d      = StArmed;
                            alarm_on_d   = 1'b0;
                            snooze_cnt_d = 3'd0;
                            missed_d     = 1'b1;
                        end else begin
                            ring_cnt_d = ring_cnt_q + 8'd1;
                        end
                    end
                end
                StSnoozed: begin
                    if (stop) begin
                        state_d      = StArmed;
                        snooze_cnt_d = 3'd0;
                    end else if (new_sec && (r_clock == snooze_tgt_q)) begin
                        state_d    = StRinging;
                        alarm_on_d = 1'b1;
                        ring_cnt_d = 8'd0;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            alarm_on_q   <= 1'b0;
            alarm_time_q <= 22'h000000;
            snooze_tgt_q <= 22'h000000;
            snooze_cnt_q <= 3'd0;
            ring_cnt_q   <= 8'd0;
            set_err_q    <= 1'b0;
            missed_q     <= 1'b0;
            prev_clk_q   <= 22'h000000;
            first_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            alarm_on_q   <= alarm_on_d;
            alarm_time_q <= alarm_time_d;
            snooze_tgt_q <= snooze_tgt_d;
            snooze_cnt_q <= snooze_cnt_d;
            ring_cnt_q   <= ring_cnt_d;
            set_err_q    <= set_err_d;
            missed_q     <= missed_d;
            prev_clk_q   <= r_clock;
            first_q      <= 1'b0;
        end
    end

    assign alarm_on   = alarm_on_q;
    assign alarm_time = alarm_time_q;
    assign snooze_cnt = snooze_cnt_q;
    assign set_err    = set_err_q;
    assign missed     = missed_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl: each stimulus row carries the outputs expected
// after the clock edge that samples it.
module tb_alarm_ctrl;

    localparam logic [21:0] TA = 22'h073000;
    localparam logic [21:0] TB = 22'h235810;

    logic        clk = 1'b0;
    logic        reset;
    logic [21:0] r_clock;
    logic        set_valid;
    logic [21:0] set_time;
    logic        set_ready;
    logic        arm_en;
    logic        snooze;
    logic        stop;
    logic        alarm_on;
    logic [21:0] alarm_time;
    logic [2:0]  snooze_cnt;
    logic        set_err;
    logic        missed;

    always #5 clk = ~clk;

    alarm_ctrl #(
        .SNOOZE_MIN(5),
        .RING_SEC  (60),
        .MAX_SNOOZE(3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .r_clock   (r_clock),
        .set_valid (set_valid),
        .set_time  (set_time),
        .set_ready (set_ready),
        .arm_en    (arm_en),
        .snooze    (snooze),
        .stop      (stop),
        .alarm_on  (alarm_on),
        .alarm_time(alarm_time),
        .snooze_cnt(snooze_cnt),
        .set_err   (set_err),
        .missed    (missed)
    );

    typedef struct {
        string       nm;
        logic        rst;
        logic [21:0] rc;
        logic        arm;
        logic        sv;
        logic [21:0] st;
        logic        snz;
        logic        stp;
        logic [28:0] exp;
    } stim_t;

    stim_t       sq[$];
    logic [28:0] sb[$];
    int          nvec = 0;
    int          nmis = 0;

    // Packs {set_ready, alarm_on, snooze_cnt, set_err, missed, alarm_time}.
    function automatic logic [28:0] ev(input logic rdy, input logic on, input logic [2:0] cnt,
                                       input logic err, input logic mis, input logic [21:0] at);
        return {rdy, on, cnt, err, mis, at};
    endfunction

    function automatic logic [28:0] obs();
        return {set_ready, alarm_on, snooze_cnt, set_err, missed, alarm_time};
    endfunction

    task automatic drv(input string nm, input logic rst, input logic [21:0] rc, input logic arm,
                       input logic sv, input logic [21:0] st, input logic snz, input logic stp,
                       input logic [28:0] e);
        stim_t s;
        s.nm  = nm;
        s.rst = rst;
        s.rc  = rc;
        s.arm = arm;
        s.sv  = sv;
        s.st  = st;
        s.snz = snz;
        s.stp = stp;
        s.exp = e;
        sq.push_back(s);
    endtask

    // Drives the next row, records its expectation, and waits just past the edge.
    task automatic step(output string nm);
        stim_t s;
        s         = sq.pop_front();
        nm        = s.nm;
        reset     = s.rst;
        r_clock   = s.rc;
        arm_en    = s.arm;
        set_valid = s.sv;
        set_time  = s.st;
        snooze    = s.snz;
        stop      = s.stp;
        sb.push_back(s.exp);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        string nm;
        logic [28:0] e, got;
        drv("rst_hold0", 1, 22'h0, 0, 0, 22'h0, 0, 0, ev(1, 0, 3'd0, 0, 0, 22'h0));
        drv("rst_hold1", 1, 22'h0, 0, 0, 22'h0, 0, 0, ev(1, 0, 3'd0, 0, 0, 22'h0));
        drv("rst_rel",   0, 22'h0, 0, 0, 22'h0, 0, 0, ev(1, 0, 3'd0, 0, 0, 22'h0));
        while (sq.size() > 0) begin
            step(nm);
            e   = sb.pop_front();
            got = obs();
            nvec++;
            if (got !== e) begin
                nmis++;
                $display("FAIL %s: got rdy=%b on=%b cnt=%0d err=%b mis=%b at=%h want rdy=%b on=%b cnt=%0d err=%b mis=%b at=%h",
                         nm, got[28], got[27], got[26:24], got[23], got[22], got[21:0],
                         e[28], e[27], e[26:24], e[23], e[22], e[21:0]);
            end
        end
    endtask

    task automatic test_set_time();
        string nm;
        logic [28:0] e, got;
        drv("wr_valid",  0, 22'h0, 0, 1, TA,         0, 0, ev(1, 0, 3'd0, 0, 0, TA));
        drv("wr_hour24", 0, 22'h0, 0, 1, 22'h240000, 0, 0, ev(1, 0, 3'd0, 1, 0, TA));
        drv("err_pulse", 0, 22'h0, 0, 0, 22'h0,      0, 0, ev(1, 0, 3'd0, 0, 0, TA));
        drv("wr_min60",  0, 22'h0, 0, 1, 22'h076000, 0, 0, ev(1, 0, 3'd0, 1, 0, TA));
        drv("wr_secA",   0, 22'h0, 0, 1, 22'h07595A, 0, 0, ev(1, 0, 3'd0, 1, 0, TA));
        drv("wr_hour30", 0, 22'h0, 0, 1, 22'h300000, 0, 0, ev(1, 0, 3'd0, 1, 0, TA));
        drv("err_clr",   0, 22'h0, 0, 0, 22'h0,      0, 0, ev(1, 0, 3'd0, 0, 0, TA));
        drv("wr_max",    0, 22'h0, 0, 1, 22'h235959, 0, 0, ev(1, 0, 3'd0, 0, 0, 22'h235959));
        drv("wr_back",   0, 22'h0, 0, 1, TA,         0, 0, ev(1, 0, 3'd0, 0, 0, TA));
        while (sq.size() > 0) begin
            step(nm);
            e   = sb.pop_front();
            got = obs();
            nvec++;
            if (got !== e) begin
                nmis++;
                $display("FAIL %s: got rdy=%b on=%b cnt=%0d err=%b mis=%b at=%h want rdy=%b on=%b cnt=%0d err=%b mis=%b at=%h",
                         nm, got[28], got[27], got[26:24], got[23], got[22], got[21:0],
                         e[28], e[27], e[26:24], e[23], e[22], e[21:0]);
            end
        end
    endtask

    task automatic test_ring_stop();
        string nm;
        logic [28:0] e, got;
        drv("arm",        0, 22'h072959, 1, 0, 22'h0,      0, 0, ev(1, 0, 3'd0, 0, 0, TA));
        drv("armed_hold", 0, 22'h072959, 1, 0, 22'h0,      0, 0, ev(1, 0, 3'd0, 0, 0, TA));
        drv("ring_match", 0, TA,         1, 0, 22'h0,      0, 0, ev(0, 1, 3'd0, 0, 0, TA));
        drv("stop_held",  0, TA,         1, 1, 22'h010203, 0, 1, ev(1, 0, 3'd0, 0, 0, TA));
        for (int i = 0; i < 3; i++) begin
            drv("held_norearm", 0, TA, 1, 0, 22'h0, 0, 0, ev(1, 0, 3'd0, 0, 0, TA));
        end
        while (sq.size() > 0) begin
            step(nm);
            e   = sb.pop_front();
            got = obs();
            nvec++;
            if (got !== e) begin
                nmis++;
                $display("FAIL %s: got rdy=%b on=%b cnt=%0d err=%b mis=%b at=%h want rdy=%b on=%b cnt=%0d err=%b mis=%b at=%h",
                         nm, got[28], got[27], got[26:24], got[23], got[22], got[21:0],
                         e[28], e[27], e[26:24], e[23], e[22], e[21:0]);
            end
        end
    endtask

    task automatic test_snooze();
        string nm;
        logic [28:0] e, got;
        drv("wr_tb",       0, 22'h235809, 1, 1, TB,    0, 0, ev(1, 0, 3'd0, 0, 0, TB));
        drv("ring_tb",     0, TB,         1, 0, 22'h0, 0, 0, ev(0, 1, 3'd0, 0, 0, TB));
        drv("snz1",        0, TB,         1, 0, 22'h0, 1, 0, ev(0, 0, 3'd1, 0, 0, TB));
        drv("snz_wait",    0, 22'h000309, 1, 0, 22'h0, 0, 0, ev(0, 0, 3'd1, 0, 0, TB));
        drv("snz_ignored", 0, 22'h000309, 1, 0, 22'h0, 1, 0, ev(0, 0, 3'd1, 0, 0, TB));
        drv("wrap_ring",   0, 22'h000310, 1, 0, 22'h0, 0, 0, ev(0, 1, 3'd1, 0, 0, TB));
        drv("snz2",        0, 22'h000310, 1, 0, 22'h0, 1, 0, ev(0, 0, 3'd2, 0, 0, TB));
        drv("ring2",       0, 22'h000810, 1, 0, 22'h0, 0, 0, ev(0, 1, 3'd2, 0, 0, TB));
        drv("snz3",        0, 22'h000810, 1, 0, 22'h0, 1, 0, ev(0, 0, 3'd3, 0, 0, TB));
        drv("ring3",       0, 22'h001310, 1, 0, 22'h0, 0, 0, ev(0, 1, 3'd3, 0, 0, TB));
        drv("snz4_stop",   0, 22'h001310, 1, 0, 22'h0, 1, 0, ev(1, 0, 3'd0, 0, 0, TB));
        while (sq.size() > 0) begin
            step(nm);
            e   = sb.pop_front();
            got = obs();
            nvec++;
            if (got !== e) begin
                nmis++;
                $display("FAIL %s: got rdy=%b on=%b cnt=%0d err=%b mis=%b at=%h want rdy=%b on=%b cnt=%0d err=%b mis=%b at=%h",
                         nm, got[28], got[27], got[26:24], got[23], got[22], got[21:0],
                         e[28], e[27], e[26:24], e[23], e[22], e[21:0]);
            end
        end
    endtask

    task automatic test_timeout();
        string nm;
        logic [28:0] e, got;
        logic [21:0] rc;
        drv("ring_to", 0, TB, 1, 0, 22'h0, 0, 0, ev(0, 1, 3'd0, 0, 0, TB));
        for (int i = 1; i <= 60; i++) begin
            rc = 22'h100000 + 22'(i);
            if (i < 60) begin
                drv("ringing_sec", 0, rc, 1, 0, 22'h0, 0, 0, ev(0, 1, 3'd0, 0, 0, TB));
            end else begin
                drv("missed_sec60", 0, rc, 1, 0, 22'h0, 0, 0, ev(1, 0, 3'd0, 0, 1, TB));
            end
            if (i == 30) begin
                drv("held_nocount", 0, rc, 1, 0, 22'h0, 0, 0, ev(0, 1, 3'd0, 0, 0, TB));
            end
        end
        drv("missed_drop", 0, rc, 1, 0, 22'h0, 0, 0, ev(1, 0, 3'd0, 0, 0, TB));
        drv("ring_again",  0, TB, 1, 0, 22'h0, 0, 0, ev(0, 1, 3'd0, 0, 0, TB));
        drv("snz_again",   0, TB, 1, 0, 22'h0, 1, 0, ev(0, 0, 3'd1, 0, 0, TB));
        drv("stop_snzd",   0, TB, 1, 0, 22'h0, 0, 1, ev(1, 0, 3'd0, 0, 0, TB));
        while (sq.size() > 0) begin
            step(nm);
            e   = sb.pop_front();
            got = obs();
            nvec++;
            if (got !== e) begin
                nmis++;
                $display("FAIL %s: got rdy=%b on=%b cnt=%0d err=%b mis=%b at=%h want rdy=%b on=%b cnt=%0d err=%b mis=%b at=%h",
                         nm, got[28], got[27], got[26:24], got[23], got[22], got[21:0],
                         e[28], e[27], e[26:24], e[23], e[22], e[21:0]);
            end
        end
    endtask

    task automatic test_disarm();
        string nm;
        logic [28:0] e, got;
        drv("tick",        0, 22'h235811, 1, 0, 22'h0, 0, 0, ev(1, 0, 3'd0, 0, 0, TB));
        drv("ring_d",      0, TB,         1, 0, 22'h0, 0, 0, ev(0, 1, 3'd0, 0, 0, TB));
        drv("disarm_ring", 0, TB,         0, 0, 22'h0, 1, 0, ev(1, 0, 3'd0, 0, 0, TB));
        drv("idle_tick",   0, 22'h235811, 0, 0, 22'h0, 0, 0, ev(1, 0, 3'd0, 0, 0, TB));
        drv("idle_nomtch", 0, TB,         0, 0, 22'h0, 0, 0, ev(1, 0, 3'd0, 0, 0, TB));
        drv("rearm",       0, 22'h235811, 1, 0, 22'h0, 0, 0, ev(1, 0, 3'd0, 0, 0, TB));
        drv("ring_e",      0, TB,         1, 0, 22'h0, 0, 0, ev(0, 1, 3'd0, 0, 0, TB));
        drv("snz_e",       0, TB,         1, 0, 22'h0, 1, 0, ev(0, 0, 3'd1, 0, 0, TB));
        drv("disarm_snzd", 0, TB,         0, 0, 22'h0, 0, 0, ev(1, 0, 3'd0, 0, 0, TB));
        while (sq.size() > 0) begin
            step(nm);
            e   = sb.pop_front();
            got = obs();
            nvec++;
            if (got !== e) begin
                nmis++;
                $display("FAIL %s: got rdy=%b on=%b cnt=%0d err=%b mis=%b at=%h want rdy=%b on=%b cnt=%0d err=%b mis=%b at=%h",
                         nm, got[28], got[27], got[26:24], got[23], got[22], got[21:0],
                         e[28], e[27], e[26:24], e[23], e[22], e[21:0]);
            end
        end
    endtask

    task automatic test_async_reset();
        string nm;
        logic [28:0] e, got;
        time t0;
        drv("arm_r",  0, 22'h235811, 1, 0, 22'h0, 0, 0, ev(1, 0, 3'd0, 0, 0, TB));
        drv("ring_r", 0, TB,         1, 0, 22'h0, 0, 0, ev(0, 1, 3'd0, 0, 0, TB));
        while (sq.size() > 0) begin
            step(nm);
            e   = sb.pop_front();
            got = obs();
            nvec++;
            if (got !== e) begin
                nmis++;
                $display("FAIL %s: got rdy=%b on=%b cnt=%0d err=%b mis=%b at=%h want rdy=%b on=%b cnt=%0d err=%b mis=%b at=%h",
                         nm, got[28], got[27], got[26:24], got[23], got[22], got[21:0],
                         e[28], e[27], e[26:24], e[23], e[22], e[21:0]);
            end
        end
        // Mid-cycle reset: outputs must clear before the next rising edge.
        t0 = $time;
        #3;
        reset = 1'b1;
        sb.push_back(ev(1, 0, 3'd0, 0, 0, 22'h0));
        #1;
        e   = sb.pop_front();
        got = obs();
        nvec++;
        if ((got !== e) || ($time - t0 >= 9)) begin
            nmis++;
            $display("FAIL async_rst: got rdy=%b on=%b cnt=%0d err=%b mis=%b at=%h want rdy=%b on=%b cnt=%0d err=%b mis=%b at=%h",
                     got[28], got[27], got[26:24], got[23], got[22], got[21:0],
                     e[28], e[27], e[26:24], e[23], e[22], e[21:0]);
        end
        drv("rst_held",  1, TB,         1, 0, 22'h0, 0, 0, ev(1, 0, 3'd0, 0, 0, 22'h0));
        drv("post_arm",  0, 22'h000000, 1, 0, 22'h0, 0, 0, ev(1, 0, 3'd0, 0, 0, 22'h0));
        drv("post_tick", 0, 22'h000001, 1, 0, 22'h0, 0, 0, ev(1, 0, 3'd0, 0, 0, 22'h0));
        drv("post_ring", 0, 22'h000000, 1, 0, 22'h0, 0, 0, ev(0, 1, 3'd0, 0, 0, 22'h0));
        while (sq.size() > 0) begin
            step(nm);
            e   = sb.pop_front();
            got = obs();
            nvec++;
            if (got !== e) begin
                nmis++;
                $display("FAIL %s: got rdy=%b on=%b cnt=%0d err=%b mis=%b at=%h want rdy=%b on=%b cnt=%0d err=%b mis=%b at=%h",
                         nm, got[28], got[27], got[26:24], got[23], got[22], got[21:0],
                         e[28], e[27], e[26:24], e[23], e[22], e[21:0]);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        r_clock   = 22'h0;
        set_valid = 1'b0;
        set_time  = 22'h0;
        arm_en    = 1'b0;
        snooze    = 1'b0;
        stop      = 1'b0;
        test_reset();
        test_set_time();
        test_ring_stop();
        test_snooze();
        test_timeout();
        test_disarm();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
